// File: rtl/ptp_perin_capture_if.sv
// Pulse-capture bus: configuration, sampled pulse input and the measured results.
interface ptp_perin_capture_if #(
  parameter int TIME_WIDTH = 30,
  parameter int CNT_WIDTH  = 11
);
  logic [TIME_WIDTH:0] input_start;
  logic                input_start_valid;
  logic                input_pulse;
  logic                input_enable;
  logic [TIME_WIDTH:0] output_rise_ts;
  logic [TIME_WIDTH:0] output_fall_ts;
  logic [TIME_WIDTH:0] output_period;
  logic [TIME_WIDTH:0] output_width;
  logic                output_valid;
  logic [CNT_WIDTH-1:0] output_count;
  logic                output_error;

  modport master (
    output input_start, input_start_valid, input_pulse, input_enable,
    input  output_rise_ts, output_fall_ts, output_period, output_width,
    input  output_valid, output_count, output_error
  );

  modport slave (
    input  input_start, input_start_valid, input_pulse, input_enable,
    output output_rise_ts, output_fall_ts, output_period, output_width,
    output output_valid, output_count, output_error
  );
endinterface

// File: rtl/ptp_perin_capture.sv
// Timestamps rising/falling edges of a periodic pulse, reports period/width 2 cycles after a rise
// (4 with PERIN_SYNC_EN, which adds a 2-flop input synchronizer); no backpressure, results are strobes.
module ptp_perin_capture #(
  parameter int TIME_WIDTH = 30,
  parameter int MIN_WIDTH  = 4,
  parameter int TIMEOUT    = 1023,
  parameter int CNT_WIDTH  = 11
) (
  input logic               clk,
  input logic               rst,
  ptp_perin_capture_if.slave bus
);
  localparam int TW = TIME_WIDTH + 1;
  localparam int PW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, SYNC, WAIT_FIRST_RISE, WAIT_FALL, WAIT_RISE, REPORT
  } state_t;

  state_t        state;
  logic [TW-1:0] now_ns;
  logic          pulse_in, pulse_q, pulse_p;
  logic          rise, fall;
  logic [TW-1:0] ts_now;
  logic [TW-1:0] rise_ts, fall_ts;
  logic [PW-1:0] phase_cnt, phase_nxt;
  logic          phase_ok, timeout;

`ifdef PERIN_SYNC_EN
  localparam int TS_LAG = 3;
  logic [1:0] sync_ff;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_ff <= '0;
    else      sync_ff <= {sync_ff[0], bus.input_pulse};
  end
  assign pulse_in = sync_ff[1];
`else
  localparam int TS_LAG = 1;
  assign pulse_in = bus.input_pulse;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) now_ns <= bus.input_start_valid ? bus.input_start : '0;
    else      now_ns <= now_ns + TW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pulse_q <= 1'b0;
      pulse_p <= 1'b0;
    end else begin
      pulse_q <= pulse_in;
      pulse_p <= pulse_q;
    end
  end

  assign rise   = pulse_q & ~pulse_p;
  assign fall   = ~pulse_q & pulse_p;
  // Edge was sampled TS_LAG cycles before it is visible here.
  assign ts_now = now_ns - TW'(TS_LAG);

  // phase_cnt tracks now_ns minus the last edge timestamp, so in the detect
  // cycle it equals phase length + 1.
  assign phase_nxt = (phase_cnt == PW'(TIMEOUT)) ? phase_cnt : phase_cnt + PW'(1);
  assign phase_ok  = phase_cnt > PW'(MIN_WIDTH);
  assign timeout   = phase_nxt == PW'(TIMEOUT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              phase_cnt <= '0;
    else if (rise || fall) phase_cnt <= PW'(2);
    else                   phase_cnt <= phase_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= IDLE;
      rise_ts            <= '0;
      fall_ts            <= '0;
      bus.output_rise_ts <= '0;
      bus.output_fall_ts <= '0;
      bus.output_period  <= '0;
      bus.output_width   <= '0;
      bus.output_valid   <= 1'b0;
      bus.output_count   <= '0;
      bus.output_error   <= 1'b0;
    end else begin
      bus.output_valid <= 1'b0;
      bus.output_error <= 1'b0;
      if (!bus.input_enable) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: state <= SYNC;
          SYNC: if (!pulse_q) state <= WAIT_FIRST_RISE;
          WAIT_FIRST_RISE: begin
            if (rise) begin
              rise_ts <= ts_now;
              state   <= WAIT_FALL;
            end
          end
          WAIT_FALL: begin
            if (fall && phase_ok) begin
              fall_ts <= ts_now;
              state   <= WAIT_RISE;
            end else if (fall || timeout) begin
              bus.output_error <= 1'b1;
              state            <= SYNC;
            end
          end
          WAIT_RISE: begin
            if (rise && phase_ok) begin
              bus.output_period  <= ts_now - rise_ts;
              bus.output_width   <= fall_ts - rise_ts;
              bus.output_rise_ts <= ts_now;
              bus.output_fall_ts <= fall_ts;
              bus.output_valid   <= 1'b1;
              if (bus.output_count != '1)
                bus.output_count <= bus.output_count + CNT_WIDTH'(1);
              rise_ts <= ts_now;
              state   <= REPORT;
            end else if (rise || timeout) begin
              bus.output_error <= 1'b1;
              state            <= SYNC;
            end
          end
          REPORT:  state <= WAIT_FALL;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ptp_perin_capture.sv
// Directed bench for ptp_perin_capture: period/width, glitch, timeout, wrap, reset, enable, saturation.
module tb_ptp_perin_capture;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [30:0] tb_ns;
  int          asserts = 0;
  int          fails = 0;
  int          valid_cnt = 0;
  int          err_cnt = 0;

  ptp_perin_capture_if #(.TIME_WIDTH(30), .CNT_WIDTH(3)) bus ();

  ptp_perin_capture #(
    .TIME_WIDTH(30), .MIN_WIDTH(4), .TIMEOUT(100), .CNT_WIDTH(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference ns clock: the value now_ns must hold in the current cycle.
  always @(posedge clk or negedge rst) begin
    if (!rst) tb_ns <= bus.input_start_valid ? bus.input_start : 31'd0;
    else      tb_ns <= tb_ns + 31'd1;
  end

  always @(negedge clk) begin
    if (bus.output_valid === 1'b1) valid_cnt++;
    if (bus.output_error === 1'b1) err_cnt++;
  end

  task automatic do_reset(input logic [30:0] start, input logic sv);
    @(negedge clk);
    bus.input_enable      = 1'b0;
    bus.input_pulse       = 1'b0;
    bus.input_start       = start;
    bus.input_start_valid = sv;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bus.input_enable = 1'b1;
  endtask

  // Drive the pulse so it is sampled in the cycle where now_ns == ts.
  task automatic set_at(input logic [30:0] ts, input logic v);
    int n = 0;
    while (tb_ns !== ts && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      asserts++; fails++;
      $display("FAIL set_at: ns %0d never reached (now %0d)", ts, tb_ns);
    end
    bus.input_pulse = v;
  endtask

  task automatic wait_strobe(input bit want_err, output logic [30:0] at, output bit seen);
    seen = 1'b0;
    at   = '0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if ((want_err ? bus.output_error : bus.output_valid) === 1'b1) begin
        seen = 1'b1;
        at   = tb_ns;
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    bus.input_enable = 1'b1;
    bus.input_pulse  = 1'b1;
    @(negedge clk);
    asserts++; if (bus.output_rise_ts !== 31'd0) begin fails++; $display("FAIL rst_rise_ts: got %0h want 0", bus.output_rise_ts); end
    asserts++; if (bus.output_fall_ts !== 31'd0) begin fails++; $display("FAIL rst_fall_ts: got %0h want 0", bus.output_fall_ts); end
    asserts++; if (bus.output_period !== 31'd0) begin fails++; $display("FAIL rst_period: got %0h want 0", bus.output_period); end
    asserts++; if (bus.output_width !== 31'd0) begin fails++; $display("FAIL rst_width: got %0h want 0", bus.output_width); end
    asserts++; if (bus.output_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %0b want 0", bus.output_valid); end
    asserts++; if (bus.output_count !== 3'd0) begin fails++; $display("FAIL rst_count: got %0d want 0", bus.output_count); end
    asserts++; if (bus.output_error !== 1'b0) begin fails++; $display("FAIL rst_error: got %0b want 0", bus.output_error); end
  endtask

  task automatic test_period;
    logic [30:0] at; bit seen;
    do_reset(31'd0, 1'b1);
    set_at(31'd10, 1'b1);
    set_at(31'd20, 1'b0);
    set_at(31'd70, 1'b1);
    wait_strobe(1'b0, at, seen);
    asserts++; if (!seen || at !== 31'd72) begin fails++; $display("FAIL per_valid_time: got %0d (seen %0b) want 72", at, seen); end
    asserts++; if (bus.output_period !== 31'd60) begin fails++; $display("FAIL per_period: got %0d want 60", bus.output_period); end
    asserts++; if (bus.output_width !== 31'd10) begin fails++; $display("FAIL per_width: got %0d want 10", bus.output_width); end
    asserts++; if (bus.output_rise_ts !== 31'd70) begin fails++; $display("FAIL per_rise_ts: got %0d want 70", bus.output_rise_ts); end
    asserts++; if (bus.output_fall_ts !== 31'd20) begin fails++; $display("FAIL per_fall_ts: got %0d want 20", bus.output_fall_ts); end
    asserts++; if (bus.output_count !== 3'd1) begin fails++; $display("FAIL per_count: got %0d want 1", bus.output_count); end
  endtask

  task automatic test_glitch;
    logic [30:0] at; bit seen;
    do_reset(31'd0, 1'b1);
    set_at(31'd10, 1'b1);
    set_at(31'd20, 1'b0);
    set_at(31'd70, 1'b1);
    wait_strobe(1'b0, at, seen);
    set_at(31'd72, 1'b0);
    wait_strobe(1'b1, at, seen);
    asserts++; if (!seen || at !== 31'd74) begin fails++; $display("FAIL glitch_err_time: got %0d (seen %0b) want 74", at, seen); end
    asserts++; if (bus.output_count !== 3'd1) begin fails++; $display("FAIL glitch_count: got %0d want 1", bus.output_count); end
    set_at(31'd100, 1'b1);
    set_at(31'd110, 1'b0);
    set_at(31'd150, 1'b1);
    wait_strobe(1'b0, at, seen);
    asserts++; if (!seen || at !== 31'd152) begin fails++; $display("FAIL glitch_next_valid: got %0d (seen %0b) want 152", at, seen); end
    asserts++; if (bus.output_period !== 31'd50) begin fails++; $display("FAIL glitch_period: got %0d want 50", bus.output_period); end
    asserts++; if (bus.output_count !== 3'd2) begin fails++; $display("FAIL glitch_count2: got %0d want 2", bus.output_count); end
  endtask

  task automatic test_timeout;
    logic [30:0] at; bit seen;
    int v0, e0;
    do_reset(31'd0, 1'b1);
    v0 = valid_cnt; e0 = err_cnt;
    set_at(31'd10, 1'b1);
    wait_strobe(1'b1, at, seen);
    asserts++; if (!seen || at !== 31'd110) begin fails++; $display("FAIL timeout_time: got %0d (seen %0b) want 110", at, seen); end
    set_at(31'd160, 1'b0);
    set_at(31'd170, 1'b0);
    asserts++; if (err_cnt - e0 !== 1) begin fails++; $display("FAIL timeout_err_count: got %0d want 1", err_cnt - e0); end
    asserts++; if (valid_cnt - v0 !== 0) begin fails++; $display("FAIL timeout_valid_count: got %0d want 0", valid_cnt - v0); end
  endtask

  task automatic test_wrap;
    logic [30:0] at; bit seen;
    do_reset(31'h7FFF_FFF0, 1'b1);
    set_at(31'h7FFF_FFF8, 1'b1);
    set_at(31'h0000_0004, 1'b0);
    set_at(31'h0000_0034, 1'b1);
    wait_strobe(1'b0, at, seen);
    asserts++; if (!seen || at !== 31'h36) begin fails++; $display("FAIL wrap_valid_time: got %0h (seen %0b) want 36", at, seen); end
    asserts++; if (bus.output_period !== 31'h3C) begin fails++; $display("FAIL wrap_period: got %0h want 3c", bus.output_period); end
    asserts++; if (bus.output_width !== 31'h0C) begin fails++; $display("FAIL wrap_width: got %0h want c", bus.output_width); end
    asserts++; if (bus.output_rise_ts !== 31'h34) begin fails++; $display("FAIL wrap_rise_ts: got %0h want 34", bus.output_rise_ts); end
  endtask

  task automatic test_reset_mid;
    logic [30:0] at; bit seen;
    do_reset(31'd0, 1'b1);
    set_at(31'd10, 1'b1);
    set_at(31'd20, 1'b0);
    set_at(31'd70, 1'b1);
    wait_strobe(1'b0, at, seen);
    set_at(31'd75, 1'b1);
    bus.input_pulse       = 1'b0;
    bus.input_start       = 31'h123;
    bus.input_start_valid = 1'b0;
    rst = 1'b0;
    #1;
    asserts++; if (bus.output_period !== 31'd0) begin fails++; $display("FAIL mid_period: got %0d want 0", bus.output_period); end
    asserts++; if (bus.output_width !== 31'd0) begin fails++; $display("FAIL mid_width: got %0d want 0", bus.output_width); end
    asserts++; if (bus.output_rise_ts !== 31'd0) begin fails++; $display("FAIL mid_rise_ts: got %0d want 0", bus.output_rise_ts); end
    asserts++; if (bus.output_fall_ts !== 31'd0) begin fails++; $display("FAIL mid_fall_ts: got %0d want 0", bus.output_fall_ts); end
    asserts++; if (bus.output_count !== 3'd0) begin fails++; $display("FAIL mid_count: got %0d want 0", bus.output_count); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    set_at(31'd10, 1'b1);
    set_at(31'd20, 1'b0);
    set_at(31'd50, 1'b1);
    wait_strobe(1'b0, at, seen);
    asserts++; if (!seen || at !== 31'd52) begin fails++; $display("FAIL mid_first_valid: got %0d (seen %0b) want 52", at, seen); end
    asserts++; if (bus.output_period !== 31'd40) begin fails++; $display("FAIL mid_period2: got %0d want 40", bus.output_period); end
    asserts++; if (bus.output_rise_ts !== 31'd50) begin fails++; $display("FAIL mid_rise_ts2: got %0d want 50", bus.output_rise_ts); end
    asserts++; if (bus.output_count !== 3'd1) begin fails++; $display("FAIL mid_count2: got %0d want 1", bus.output_count); end
  endtask

  task automatic test_enable;
    logic [30:0] at; bit seen;
    int e0;
    do_reset(31'd0, 1'b1);
    set_at(31'd10, 1'b1);
    set_at(31'd20, 1'b0);
    set_at(31'd70, 1'b1);
    wait_strobe(1'b0, at, seen);
    set_at(31'd80, 1'b1);
    bus.input_enable = 1'b0;
    e0 = err_cnt;
    set_at(31'd300, 1'b1);
    asserts++; if (err_cnt - e0 !== 0) begin fails++; $display("FAIL en_no_error: got %0d errors want 0", err_cnt - e0); end
    asserts++; if (bus.output_period !== 31'd60) begin fails++; $display("FAIL en_held_period: got %0d want 60", bus.output_period); end
    asserts++; if (bus.output_count !== 3'd1) begin fails++; $display("FAIL en_held_count: got %0d want 1", bus.output_count); end
    bus.input_enable = 1'b1;
    set_at(31'd310, 1'b0);
    set_at(31'd320, 1'b1);
    set_at(31'd330, 1'b0);
    set_at(31'd380, 1'b1);
    wait_strobe(1'b0, at, seen);
    asserts++; if (!seen || at !== 31'd382) begin fails++; $display("FAIL en_valid_time: got %0d (seen %0b) want 382", at, seen); end
    asserts++; if (bus.output_count !== 3'd2) begin fails++; $display("FAIL en_count2: got %0d want 2", bus.output_count); end
  endtask

  task automatic test_saturation;
    int v0;
    do_reset(31'd0, 1'b1);
    v0 = valid_cnt;
    for (int k = 0; k <= 10; k++) begin
      set_at(31'(10 + 20 * k), 1'b1);
      set_at(31'(15 + 20 * k), 1'b0);
    end
    set_at(31'd230, 1'b0);
    asserts++; if (bus.output_count !== 3'd7) begin fails++; $display("FAIL sat_count: got %0d want 7", bus.output_count); end
    asserts++; if (valid_cnt - v0 !== 10) begin fails++; $display("FAIL sat_valid_pulses: got %0d want 10", valid_cnt - v0); end
    asserts++; if (bus.output_period !== 31'd20) begin fails++; $display("FAIL sat_period: got %0d want 20", bus.output_period); end
  endtask

  initial begin
    bus.input_start       = 31'd0;
    bus.input_start_valid = 1'b1;
    bus.input_pulse       = 1'b0;
    bus.input_enable      = 1'b0;
    test_reset;
    test_period;
    test_glitch;
    test_timeout;
    test_wrap;
    test_reset_mid;
    test_enable;
    test_saturation;
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule

// File: doc/ptp_perin_capture.md
Name: ptp_perin_capture

Overview:
- Input-side counterpart of the PTP period-out generator: samples an incoming periodic pulse and timestamps each rising and falling edge against a local 31-bit ns counter.
- Reports the measured period, the high width and a saturating pulse count, and flags malformed pulse trains.
- Sits at the timing-input boundary. Its outputs feed loopback checks of the period-out block and external PPS/perout monitoring.

Parameters:
- TIME_WIDTH, 30: ns values are TIME_WIDTH+1 bits wide (31 bits by default).
- MIN_WIDTH, 4: minimum legal high or low phase, in cycles.
- TIMEOUT, 1023: maximum number of cycles without an edge before an error is raised.
- CNT_WIDTH, 11: width of the pulse counter.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- input_start  input  TIME_WIDTH+1  initial value for the ns counter.
- input_start_valid  input  1  when high during reset, now_ns loads input_start; otherwise it loads 0.
- input_pulse  input  1  pulse train to measure, synchronous to clk unless the optional feature is enabled.
- input_enable  input  1  capture enable; when low the block returns to IDLE.
- output_rise_ts  output  TIME_WIDTH+1  timestamp of the latest rising edge.
- output_fall_ts  output  TIME_WIDTH+1  timestamp of the latest falling edge.
- output_period  output  TIME_WIDTH+1  time from the previous rising edge to the latest rising edge.
- output_width  output  TIME_WIDTH+1  latest fall_ts minus the rise_ts before it.
- output_valid  output  1  one-cycle strobe when period and width are updated.
- output_count  output  CNT_WIDTH  number of reported periods; saturates at all-ones.
- output_error  output  1  one-cycle strobe on a glitch or a timeout.

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs are 0.
  - State goes to IDLE.
  - now_ns loads input_start if input_start_valid, else 0.
- now_ns:
  - Increments by 1 every cycle after reset.
  - Wraps modulo 2^(TIME_WIDTH+1).
- Edge detection:
  - pulse_q is input_pulse registered once; pulse_p is the previous value of pulse_q.
  - A rise is pulse_q=1 with pulse_p=0; a fall is pulse_q=1 to 0 in the same way.
  - The timestamp is the value of now_ns in the cycle input_pulse is first sampled high (or low), i.e. now_ns minus 1 at the detect cycle.
- All differences are computed modulo 2^(TIME_WIDTH+1), so wrap-around yields the correct positive value.
- State machine:
  - IDLE: wait for input_enable=1, then go to SYNC.
  - SYNC:
    - Discard any partial pulse: wait for pulse_q=0.
    - Then go to WAIT_FIRST_RISE.
  - WAIT_FIRST_RISE:
    - On a rise: latch rise_ts, go to WAIT_FALL.
    - No period is reported for the first rise.
  - WAIT_FALL:
    - On a fall, if high phase >= MIN_WIDTH: latch fall_ts, go to WAIT_RISE.
    - On a fall with high phase < MIN_WIDTH: glitch.
  - WAIT_RISE:
    - On a rise, if low phase >= MIN_WIDTH: go to REPORT.
    - On a rise with low phase < MIN_WIDTH: glitch.
  - REPORT (1 cycle):
    - Update output_period = new_rise - old rise_ts.
    - Update output_width = fall_ts - old rise_ts.
    - Update output_rise_ts = new_rise and output_fall_ts = fall_ts.
    - Pulse output_valid and increment output_count (saturating).
    - Return to WAIT_FALL with rise_ts = new_rise.
  - Glitch or timeout:
    - Pulse output_error for 1 cycle.
    - Do not update outputs or the count.
    - Go to SYNC.
- Latency: output_valid is asserted exactly 2 cycles after the cycle in which the second rise is first sampled (1 cycle detect, 1 cycle REPORT).
- Phase cycle counter:
  - Resets on every edge.
  - Saturates at TIMEOUT.
  - Reaching TIMEOUT in WAIT_FALL or WAIT_RISE raises a timeout error.
- input_enable=0 in any state:
  - Go to IDLE on the next cycle.
  - Held output values are retained.
  - output_valid and output_error are 0.
- An edge arriving in the REPORT cycle is impossible, since MIN_WIDTH >= 2. MIN_WIDTH < 2 is illegal.

Optional Feature:
- PERIN_SYNC_EN defined:
  - A 2-flop synchronizer precedes pulse_q, for asynchronous input_pulse.
  - Timestamps are compensated by subtracting 2, so the reported values are identical to the non-synchronized build.
  - output_valid latency is 2 cycles more, 4 cycles total.
- PERIN_SYNC_EN undefined: no synchronizer; input_pulse must be synchronous to clk.

Test Plan:
- Period 60, width 10: input_start=0, input_pulse high for now_ns 10..19, low, high again at 70 -> output_valid 2 cycles after the rise at 70; period=60, width=10, rise_ts=70, fall_ts=20, count=1.
- Glitch: MIN_WIDTH=4, pulse high for 2 cycles after a valid first rise -> output_error strobe, count unchanged, then SYNC; the next two clean rises 50 apart report period=50.
- Timeout: TIMEOUT=100, pulse held high 150 cycles after a rise -> output_error exactly 100 cycles after the rise; no output_valid.
- Wrap-around:
  - Stimulus: input_start=0x7FFFFFF0; rise at 0x7FFFFFF8; fall at 0x00000004; rise at 0x00000034.
  - Required response: period=0x3C, width=0x0C.
- Reset mid-operation:
  - Stimulus: rst=0 asserted while in WAIT_FALL, released.
  - Required response: all outputs are 0 immediately; the first report needs two fresh rises.
- Saturation: CNT_WIDTH=3, 10 clean periods -> output_count stops at 7; output_valid continues to pulse.
